// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue/writeback sequencer: opcodes,
// FSM encoding and instruction field layout.
package alu_issue_pkg;

  localparam int NREGS  = 8;
  localparam int WIDTH  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_NOT = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_DECODE    = 2'd1;
  localparam logic [1:0] ST_EXECUTE   = 2'd2;
  localparam logic [1:0] ST_WRITEBACK = 2'd3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 7;
  localparam int RT_HI  = 6;
  localparam int RT_LO  = 4;
  localparam int CLR_BIT = 3;

  // Latched instruction; the reserved low bits are not kept.
  typedef struct packed {
    logic [2:0]        opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              clr;
  } instr_t;

  function automatic instr_t decode_instr(input logic [15:0] raw);
    instr_t d;
    d.opc = raw[OPC_HI:OPC_LO];
    d.rd  = raw[RD_HI:RD_LO];
    d.rs  = raw[RS_HI:RS_LO];
    d.rt  = raw[RT_HI:RT_LO];
    d.clr = raw[CLR_BIT];
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8x32 register file: R0 hardwired to zero, one write port, two operand
// read ports captured by the parent, one combinational debug port.
module alu_issue_regfile
  import alu_issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [REG_AW-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [REG_AW-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [WIDTH-1:0]  dbg_data_o
);

  logic [NREGS-1:0][WIDTH-1:0] rf_q;

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_q <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : rf_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Four-cycle issue/writeback sequencer wrapped around an external
// combinational ALU: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
module alu_issue_sequencer
  import alu_issue_pkg::*;
(
  input  logic              Clock_i,
  input  logic              Reset_i,
  input  logic              InstrValid_i,
  input  logic [15:0]       Instr_i,
  output logic              InstrReady_o,
  input  logic              LoadEn_i,
  input  logic [REG_AW-1:0] LoadAddr_i,
  input  logic [WIDTH-1:0]  LoadData_i,
  output logic [WIDTH-1:0]  AluR2_o,
  output logic [WIDTH-1:0]  AluR3_o,
  output logic [2:0]        AluOpcode_o,
  output logic              AluShouldClear_o,
  input  logic [WIDTH-1:0]  AluR1_i,
  output logic              Done_o,
  output logic [WIDTH-1:0]  Result_o,
  input  logic [REG_AW-1:0] DbgAddr_i,
  output logic [WIDTH-1:0]  DbgData_o
);

  logic [1:0]       state_q, state_d;
  instr_t           ir_q, ir_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [WIDTH-1:0] rs_data, rt_data;
  logic             idle, wb;
  logic             rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [WIDTH-1:0] rf_wdata;
  logic             unused_rsvd;

  assign unused_rsvd = ^Instr_i[2:0];

  assign idle = (state_q == ST_IDLE);
  assign wb   = (state_q == ST_WRITEBACK);

  // A pending preload blocks acceptance so it always wins the IDLE cycle.
  assign InstrReady_o = idle & ~Reset_i & ~LoadEn_i;

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    aluout_d = aluout_q;
    case (state_q)
      ST_IDLE: begin
        if (InstrValid_i && InstrReady_o) begin
          ir_d    = decode_instr(Instr_i);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d     = rs_data;
        b_d     = rt_data;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        aluout_d = AluR1_i;
        state_d  = ST_WRITEBACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  // Writeback and preload never collide: they belong to different states.
  assign rf_we    = wb | (idle & LoadEn_i);
  assign rf_waddr = wb ? ir_q.rd  : LoadAddr_i;
  assign rf_wdata = wb ? aluout_q : LoadData_i;

  alu_issue_regfile u_rf (
    .clk_i      (Clock_i),
    .rst_i      (Reset_i),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .raddr_a_i  (ir_q.rs),
    .rdata_a_o  (rs_data),
    .raddr_b_i  (ir_q.rt),
    .rdata_b_o  (rt_data),
    .dbg_addr_i (DbgAddr_i),
    .dbg_data_o (DbgData_o)
  );

  assign AluR2_o          = a_q;
  assign AluR3_o          = b_q;
  assign AluOpcode_o      = ir_q.opc;
  assign AluShouldClear_o = ir_q.clr;

  assign Done_o   = wb & ~Reset_i;
  assign Result_o = Done_o ? aluout_q : '0;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Randomized bench for alu_issue_sequencer with a transaction-level model
// and a bench-side combinational ALU.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        InstrValid = 1'b0;
  logic [15:0] Instr = '0;
  logic        InstrReady;
  logic        LoadEn = 1'b0;
  logic [2:0]  LoadAddr = '0;
  logic [31:0] LoadData = '0;
  logic [31:0] AluR2, AluR3, AluR1;
  logic [2:0]  AluOpcode;
  logic        AluShouldClear;
  logic        Done;
  logic [31:0] Result;
  logic [2:0]  DbgAddr = '0;
  logic [31:0] DbgData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_issue_sequencer dut (
    .Clock_i(clk), .Reset_i(Reset), .InstrValid_i(InstrValid), .Instr_i(Instr),
    .InstrReady_o(InstrReady), .LoadEn_i(LoadEn), .LoadAddr_i(LoadAddr),
    .LoadData_i(LoadData), .AluR2_o(AluR2), .AluR3_o(AluR3),
    .AluOpcode_o(AluOpcode), .AluShouldClear_o(AluShouldClear), .AluR1_i(AluR1),
    .Done_o(Done), .Result_o(Result), .DbgAddr_i(DbgAddr), .DbgData_o(DbgData)
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic clr);
    case (op)
      3'd0: return a;
      3'd1: return ~a;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return clr ? b : (a | b);
      3'd5: return a & b;
      3'd6: return a ^ b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  always_comb AluR1 = alu_f(AluOpcode, AluR2, AluR3, AluShouldClear);

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [2:0] rt,
                                      input logic clr);
    return {op, rd, rs, rt, clr, 3'b000};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Model: on acceptance the result is computed at once from the model RF;
  // cnt counts edges until the writeback lands.
  logic [31:0] m_rf [8];
  int          cnt = 0;
  logic [2:0]  m_rd, m_op;
  logic        m_clr;
  logic [31:0] m_a, m_b, m_res;
  bit          chk_en = 0;

  initial begin
    foreach (m_rf[i]) m_rf[i] = '0;
    forever begin
      @(posedge clk);
      if (Reset) begin
        foreach (m_rf[i]) m_rf[i] = '0;
        cnt = 0;
        chk_en = 1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0 && m_rd != 3'd0) m_rf[m_rd] = m_res;
      end else if (LoadEn) begin
        if (LoadAddr != 3'd0) m_rf[LoadAddr] = LoadData;
      end else if (InstrValid) begin
        m_op  = Instr[15:13];
        m_rd  = Instr[12:10];
        m_a   = m_rf[Instr[9:7]];
        m_b   = m_rf[Instr[6:4]];
        m_clr = Instr[3];
        m_res = alu_f(m_op, m_a, m_b, m_clr);
        cnt   = 3;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", 32'(InstrReady), 32'(cnt == 0 && !Reset && !LoadEn));
        chk("done", 32'(Done), 32'(cnt == 1 && !Reset));
        chk("result", Result, (cnt == 1 && !Reset) ? m_res : 32'd0);
        chk("dbg", DbgData, m_rf[DbgAddr]);
        if (cnt == 2 && !Reset) begin
          chk("alu_r2", AluR2, m_a);
          chk("alu_r3", AluR3, m_b);
          chk("alu_op", 32'(AluOpcode), 32'(m_op));
          chk("alu_clr", 32'(AluShouldClear), 32'(m_clr));
        end
      end
    end
  end

  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk); #1;
    LoadEn = 1'b1; LoadAddr = a; LoadData = d;
    @(negedge clk); #1;
    LoadEn = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input logic clr);
    int n = 0;
    @(negedge clk); #1;
    InstrValid = 1'b1; Instr = enc(op, rd, rs, rt, clr);
    while (!InstrReady && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n >= 20), 32'd0);
    @(posedge clk); #1;
    InstrValid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic lit(input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk); #1;
    DbgAddr = a;
    #1 chk($sformatf("lit_r%0d", a), DbgData, exp);
  endtask

  function automatic logic [31:0] rnd_data();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    #1 Reset = 1'b0;

    // Reset clears preloaded state
    preload(3'd1, 32'd5);
    @(negedge clk); #1 Reset = 1'b1;
    #1 chk("ready_in_reset", 32'(InstrReady), 32'd0);
    @(negedge clk); #1 Reset = 1'b0;
    #1 chk("ready_post_reset", 32'(InstrReady), 32'd1);
    for (int a = 0; a < 8; a++) lit(3'(a), 32'd0);

    preload(3'd1, 32'd7);
    preload(3'd2, 32'd9);
    issue(3'd2, 3'd3, 3'd1, 3'd2, 1'b0);
    lit(3'd3, 32'd16);

    preload(3'd1, 32'hFFFF_FFFF);
    preload(3'd2, 32'd1);
    issue(3'd7, 3'd4, 3'd1, 3'd2, 1'b0);
    lit(3'd4, 32'd1);
    issue(3'd7, 3'd4, 3'd2, 3'd1, 1'b0);
    lit(3'd4, 32'd0);

    preload(3'd1, 32'hF0);
    preload(3'd2, 32'h0F);
    issue(3'd4, 3'd5, 3'd1, 3'd2, 1'b1);
    lit(3'd5, 32'h0F);
    issue(3'd4, 3'd5, 3'd1, 3'd2, 1'b0);
    lit(3'd5, 32'hFF);

    issue(3'd1, 3'd1, 3'd0, 3'd0, 1'b0);
    issue(3'd2, 3'd1, 3'd1, 3'd1, 1'b0);
    lit(3'd1, 32'hFFFF_FFFE);
    issue(3'd0, 3'd0, 3'd1, 3'd0, 1'b0);
    lit(3'd0, 32'd0);

    // Reset landing in the EXECUTE cycle
    preload(3'd1, 32'd3);
    preload(3'd2, 32'd4);
    @(negedge clk); #1;
    InstrValid = 1'b1; Instr = enc(3'd2, 3'd3, 3'd1, 3'd2, 1'b0);
    @(posedge clk); #1 InstrValid = 1'b0;
    @(posedge clk); #1 Reset = 1'b1;
    @(posedge clk); #1 Reset = 1'b0;
    lit(3'd3, 32'd0);
    preload(3'd1, 32'd3);
    preload(3'd2, 32'd4);
    issue(3'd2, 3'd3, 3'd1, 3'd2, 1'b0);
    lit(3'd3, 32'd7);

    // Preload and instruction offered together
    @(negedge clk); #1;
    LoadEn = 1'b1; LoadAddr = 3'd6; LoadData = 32'hAA;
    InstrValid = 1'b1; Instr = enc(3'd0, 3'd7, 3'd6, 3'd0, 1'b0);
    #1 chk("ready_under_load", 32'(InstrReady), 32'd0);
    @(negedge clk); #1 LoadEn = 1'b0;
    #1 chk("ready_after_load", 32'(InstrReady), 32'd1);
    @(posedge clk); #1 InstrValid = 1'b0;
    repeat (3) @(posedge clk);
    lit(3'd7, 32'hAA);
    lit(3'd6, 32'hAA);

    // Free-running random traffic
    repeat (2000) begin
      @(negedge clk); #1;
      Reset      = ($urandom_range(0, 99) == 0);
      LoadEn     = ($urandom_range(0, 3) == 0);
      LoadAddr   = 3'($urandom);
      LoadData   = rnd_data();
      InstrValid = ($urandom_range(0, 1) == 1);
      Instr      = 16'($urandom);
      DbgAddr    = 3'($urandom);
    end
    @(negedge clk); #1;
    Reset = 1'b0; LoadEn = 1'b0; InstrValid = 1'b0;
    repeat (6) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
